// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one SPI master.
// One transaction at a time: IDLE (arbitrate) -> START -> WAIT (done/timeout) -> RESP.
module spi_txn_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic [NREQ*DW-1:0] req_data_i,
  input  logic [NREQ-1:0]    req_slave_i,
  output logic [NREQ-1:0]    rsp_valid_o,
  output logic [DW-1:0]      rsp_data_o,
  output logic               rsp_err_o,
  output logic               m_start_o,
  output logic [DW-1:0]      m_data_o,
  output logic               m_cs1_sel_o,
  output logic               m_cs2_sel_o,
  input  logic               m_done_i,
  input  logic [DW-1:0]      m_rx_data_i,
  output logic [2:0]         grant_id_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [2:0]      last_grant_q, last_grant_d;
  logic [2:0]      id_q, id_d;
  logic [DW-1:0]   data_q, data_d;
  logic            slave_q, slave_d;
  logic [15:0]     timer_q, timer_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;

  logic            win_found_s;
  logic [2:0]      win_id_s;
  logic [3:0]      cand_s;
  logic            active_s;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = 3'd0;
    cand_s      = 4'd0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = {1'b0, last_grant_q} + 4'(k);
      if (cand_s >= 4'(NREQ)) begin
        cand_s = cand_s - 4'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found_s && cand_s == 4'(i) && req_valid_i[i]) begin
          win_found_s = 1'b1;
          win_id_s    = 3'(i);
        end else begin
          win_found_s = win_found_s;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 3'(NREQ - 1);
      id_q         <= 3'd0;
      data_q       <= '0;
      slave_q      <= 1'b0;
      timer_q      <= 16'd0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      data_q       <= data_d;
      slave_q      <= slave_d;
      timer_q      <= timer_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Next-state logic; m_done is only honoured in WAIT and beats a same-cycle timeout.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    data_d       = data_q;
    slave_d      = slave_q;
    timer_d      = timer_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          id_d    = win_id_s;
          for (int i = 0; i < NREQ; i++) begin
            if (win_id_s == 3'(i)) begin
              data_d  = req_data_i[i*DW +: DW];
              slave_d = req_slave_i[i];
            end else begin
              data_d  = data_d;
            end
          end
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        timer_d = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (m_done_i) begin
          rsp_data_d = m_rx_data_i;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (timer_q == 16'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_RESP: begin
        last_grant_d = id_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Per-requester handshake decode.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_o[i] = (state_q == S_IDLE) && win_found_s && (win_id_s == 3'(i));
      rsp_valid_o[i] = (state_q == S_RESP) && (id_q == 3'(i));
    end
  end

  assign active_s    = (state_q == S_START) || (state_q == S_WAIT);
  assign m_start_o   = (state_q == S_START);
  assign m_data_o    = data_q;
  assign m_cs1_sel_o = active_s && !slave_q;
  assign m_cs2_sel_o = active_s && slave_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign grant_id_o  = id_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one SPI master (16-bit MOSI/MISO frame, two chip selects) between NREQ requesters.
- Accepts one request at a time via round-robin arbitration and drives the master's select/data lines.
- Pulses start, waits for done or timeout, then returns the captured MISO word to the owning requester.
- Sits between the control/test logic and the SPI master; it is the only block that starts the master.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 16, SPI frame width in bits.
- TIMEOUT, 1023, cycles in WAIT without m_done before abort (1..65535).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester transaction request
- req_ready  out  NREQ  per-requester accept; combinational
- req_data  in  NREQ*DW  TX word; requester i uses bits [i*DW +: DW]
- req_slave  in  NREQ  target per requester: 0 = slave 1, 1 = slave 2
- rsp_valid  out  NREQ  one-cycle response pulse to the owning requester
- rsp_data  out  DW  received MISO word; 0 on error
- rsp_err  out  1  timeout flag, qualified by any rsp_valid bit
- m_start  out  1  one-cycle start pulse to the SPI master
- m_data  out  DW  TX word to the master
- m_cs1_sel  out  1  select slave 1
- m_cs2_sel  out  1  select slave 2
- m_done  in  1  master frame-complete pulse
- m_rx_data  in  DW  master MISO word, valid with m_done
- grant_id  out  3  owner of the current transaction
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset:
  - state = IDLE; all outputs are 0.
  - last_grant = NREQ-1, so requester 0 wins first.
  - Timer cleared.
  - Reset in any state aborts the transaction. No rsp_valid is issued and m_start is not re-pulsed.
- FSM states: IDLE -> START -> WAIT -> RESP -> IDLE.
- IDLE arbitration:
  - Winner = first i with req_valid[i], searched from last_grant+1 upward, wrapping modulo NREQ.
  - req_ready[winner] = 1 in this same cycle; all other req_ready bits are 0.
  - Acceptance is req_valid & req_ready. On acceptance, latch req_data, req_slave and id, then go to START.
  - With no req_valid, stay in IDLE.
  - req_ready is 0 in all other states.
- START (1 cycle):
  - m_start = 1; m_data = latched word.
  - m_cs1_sel = (slave == 0); m_cs2_sel = (slave == 1). The selects are one-hot and stay constant through WAIT.
  - Timer is cleared. Go to WAIT.
- WAIT:
  - m_start = 0; m_data and selects are held.
  - m_done sampled only here. m_done in IDLE, START or RESP is ignored.
  - On m_done: capture m_rx_data, err = 0, go to RESP.
  - Otherwise the timer increments. If timer == TIMEOUT-1 and no m_done this cycle: err = 1, data = 0, go to RESP.
  - m_done in the timeout cycle wins (err = 0).
- RESP (1 cycle):
  - rsp_valid[id] = 1; rsp_data and rsp_err driven. There is no backpressure.
  - m_cs1_sel = m_cs2_sel = 0.
  - last_grant = id. Go to IDLE.
- Latency:
  - Accept at cycle T; m_start at T+1.
  - m_done at cycle D ≥ T+2 gives rsp_valid at D+1.
  - Next acceptance no earlier than D+2.
- Fairness:
  - A requester that just completed has lowest priority next round.
  - A continuously asserting requester cannot starve another.
- rsp_data, rsp_err and grant_id hold their values until the next RESP.
- busy = 1 from START through RESP inclusive.

Test Plan:
- Single request: req_valid[0] = 1, req_data0 = 16'hA5C3, slave = 0.
  - Expect req_ready[0] the same cycle, m_start next cycle with m_data = A5C3 and m_cs1_sel = 1.
  - Drive m_done 20 cycles later with m_rx_data = 16'h3C5A -> rsp_valid[0] one cycle later, rsp_data = 3C5A, rsp_err = 0.
- Contention: req_valid = 2'b11 held continuously, with master done 5 cycles after each start.
  - Expect grant order 0, 1, 0, 1.
  - Each rsp_valid goes only to the owner.
- Slave routing: requester 1 with slave = 1 -> m_cs2_sel = 1 and m_cs1_sel = 0 from START to the end of WAIT; both selects 0 in RESP and IDLE.
- Timeout: TIMEOUT = 8, m_done never asserted.
  - Expect rsp_valid 8 cycles after WAIT entry, rsp_err = 1, rsp_data = 0.
  - Next request is accepted normally.
- Reset mid-WAIT: reset pulsed during WAIT.
  - Expect all outputs 0 next cycle and no rsp_valid.
  - Requester 0 wins the next arbitration.
- Stray done: m_done pulsed in IDLE and in START -> no response and no state change; the transaction completes only on a later m_done.
